fan_tach_meter: RTL and testbench

Measures the speed of the fan by counting rising edges of the fan tachometer signal over a fixed gate window of system clocks. It is the receive-side counterpart of the clock divider that drives the fan. The divider generates a frequency; this block recovers one from the fan's feedback. It sits between the tach input pad and the fan control loop, and supplies a per-window edge count, a valid strobe, and overflow and stall flags.

---
 rtl/fan_tach_meter.sv | 127 ++++++++++++
 tb/tb_fan_tach_meter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: synchronizes and debounces the tach input, then counts
// rising edges over a fixed gate window and reports count, overflow and stall.
module fan_tach_meter #(
   parameter int GATE_CYCLES   = 100000,
   parameter int DEBOUNCE      = 4,
   parameter int CNT_W         = 16,
   parameter int STALL_WINDOWS = 3
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             tach_in,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             overflow,
   output logic             stall
);

   localparam int GATE_W  = $clog2(GATE_CYCLES);
   localparam int RUN_W   = $clog2(DEBOUNCE + 1);
   localparam int STALL_W = $clog2(STALL_WINDOWS + 1);

   localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_WINDOWS);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t             state;
   logic               s1;
   logic               s2;
   logic               filt;
   logic               filt_d;
   logic               rise;
   logic [RUN_W-1:0]   run;
   logic [GATE_W-1:0]  gate_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic               sat;
   logic [STALL_W-1:0] zero_run;

   logic [CNT_W-1:0]   edge_next;
   logic               edge_sat;
   logic [STALL_W-1:0] zero_next;

   // The filter only changes level after DEBOUNCE consecutive disagreeing samples.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         run    <= '0;
      end else begin
         s1     <= tach_in;
         s2     <= s1;
         filt_d <= filt;
         if (s2 != filt) begin
            if (run == RUN_LAST) begin
               filt <= s2;
               run  <= '0;
            end else begin
               run <= run + 1'b1;
            end
         end else begin
            run <= '0;
         end
      end
   end

   assign rise = filt & ~filt_d;

   always_comb begin
      edge_next = edge_cnt;
      if (rise && (edge_cnt != CNT_MAX)) begin
         edge_next = edge_cnt + 1'b1;
      end
      edge_sat = rise && (edge_next == CNT_MAX);

      zero_next = '0;
      if (edge_next == '0) begin
         zero_next = (zero_run == STALL_MAX) ? zero_run : zero_run + 1'b1;
      end
   end

   // A rise during the closing cycle still belongs to the window being closed.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         sat         <= 1'b0;
         zero_run    <= '0;
         count_out   <= '0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
         stall       <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (!enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
         end else if (state == IDLE) begin
            state    <= MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
         end else if (gate_cnt == GATE_LAST) begin
            count_out   <= edge_next;
            overflow    <= sat | edge_sat;
            count_valid <= 1'b1;
            zero_run    <= zero_next;
            stall       <= (zero_next >= STALL_MAX);
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
         end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_next;
            sat      <= sat | edge_sat;
         end
      end
   end

endmodule

// File: tb/tb_fan_tach_meter.sv
// Two meters (20- and 80-cycle gates) share one stimulus stream; a window-level
// model predicts each count_valid and a monitor compares whenever one appears.
module tb_fan_tach_meter;

   localparam int D    = 2;
   localparam int CW   = 4;
   localparam int SW   = 2;
   localparam int MAXC = 15;

   logic          clk_in  = 1'b0;
   logic          rst_n   = 1'b1;
   logic          enable  = 1'b0;
   logic          tach_in = 1'b0;
   logic [CW-1:0] cnt_a;
   logic [CW-1:0] cnt_b;
   logic          valid_a;
   logic          valid_b;
   logic          ov_a;
   logic          ov_b;
   logic          st_a;
   logic          st_b;

   fan_tach_meter #(.GATE_CYCLES(20), .DEBOUNCE(D), .CNT_W(CW), .STALL_WINDOWS(SW)) dut_a (
      .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .tach_in(tach_in),
      .count_out(cnt_a), .count_valid(valid_a), .overflow(ov_a), .stall(st_a));

   fan_tach_meter #(.GATE_CYCLES(80), .DEBOUNCE(D), .CNT_W(CW), .STALL_WINDOWS(SW)) dut_b (
      .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .tach_in(tach_in),
      .count_out(cnt_b), .count_valid(valid_b), .overflow(ov_b), .stall(st_b));

   always #5 clk_in = ~clk_in;

   typedef struct {
      int at;
      int cnt;
      int ov;
      int st;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   rise_q[$];
   int   edge_no   = 0;
   int   total     = 0;
   int   bad       = 0;
   int   model_rise;
   bit   clean_lvl = 1'b0;
   bit   m_open[2];
   int   m_start[2];
   int   m_edges[2];
   int   m_zero[2];
   int   hold_cnt[2];
   int   hold_ov[2];
   int   hold_st[2];

   function automatic int gateOf(input int d);
      return (d == 0) ? 20 : 80;
   endfunction

   function automatic int qSize(input int d);
      return (d == 0) ? q_a.size() : q_b.size();
   endfunction

   function automatic int qHeadAt(input int d);
      return (d == 0) ? q_a[0].at : q_b[0].at;
   endfunction

   function automatic exp_t qPop(input int d);
      if (d == 0) return q_a.pop_front();
      return q_b.pop_front();
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkDut(input string name, input int d, input int cnt, input int ov, input int st);
      checkOutput({name, " count_out"}, (d == 0) ? int'(cnt_a) : int'(cnt_b), cnt);
      checkOutput({name, " overflow"},  (d == 0) ? int'(ov_a)  : int'(ov_b),  ov);
      checkOutput({name, " stall"},     (d == 0) ? int'(st_a)  : int'(st_b),  st);
   endtask

   // A window opens on the first edge enable is seen high, absorbs rises on the
   // following gate edges, and closes on the last of them.
   task automatic modelStep(input int d, input int n_rise);
      exp_t e;
      if (!rst_n) begin
         m_open[d] = 1'b0;
         m_zero[d] = 0;
      end else if (!enable) begin
         m_open[d] = 1'b0;
      end else if (!m_open[d]) begin
         m_open[d]  = 1'b1;
         m_start[d] = edge_no;
         m_edges[d] = 0;
      end else begin
         m_edges[d] += n_rise;
         if (edge_no - m_start[d] == gateOf(d)) begin
            e.at      = edge_no;
            e.cnt     = (m_edges[d] > MAXC) ? MAXC : m_edges[d];
            e.ov      = (m_edges[d] >= MAXC) ? 1 : 0;
            m_zero[d] = (e.cnt == 0) ? ((m_zero[d] < SW) ? m_zero[d] + 1 : SW) : 0;
            e.st      = (m_zero[d] >= SW) ? 1 : 0;
            if (d == 0) q_a.push_back(e);
            else q_b.push_back(e);
            m_start[d] = edge_no;
            m_edges[d] = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk_in);
      edge_no++;
      model_rise = 0;
      while (rise_q.size() > 0 && rise_q[0] <= edge_no) begin
         if (rise_q[0] == edge_no) model_rise++;
         void'(rise_q.pop_front());
      end
      for (int d = 0; d < 2; d++) modelStep(d, model_rise);
   end

   task automatic monitorCheck(input int d, input int v, input int c, input int o, input int s);
      exp_t  e;
      string tag;
      tag = (d == 0) ? "A" : "B";
      while (qSize(d) > 0 && qHeadAt(d) < edge_no) begin
         e = qPop(d);
         total++;
         bad++;
         $display("[TB] FAIL %s count_valid missing: got none by edge %0d, expected at edge %0d", tag, edge_no, e.at);
         hold_cnt[d] = e.cnt;
         hold_ov[d]  = e.ov;
         hold_st[d]  = e.st;
      end
      if (v != 0) begin
         if (qSize(d) == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s count_valid unexpected: got 1, expected 0 at edge %0d", tag, edge_no);
         end else begin
            e = qPop(d);
            checkOutput({tag, " valid edge"}, edge_no, e.at);
            checkOutput({tag, " count_out"}, c, e.cnt);
            checkOutput({tag, " overflow"}, o, e.ov);
            checkOutput({tag, " stall"}, s, e.st);
            hold_cnt[d] = e.cnt;
            hold_ov[d]  = e.ov;
            hold_st[d]  = e.st;
         end
      end else begin
         checkOutput({tag, " held count_out"}, c, hold_cnt[d]);
         checkOutput({tag, " held overflow"}, o, hold_ov[d]);
         checkOutput({tag, " held stall"}, s, hold_st[d]);
      end
   endtask

   initial forever begin
      @(negedge clk_in);
      monitorCheck(0, int'(valid_a), int'(cnt_a), int'(ov_a), int'(st_a));
      monitorCheck(1, int'(valid_b), int'(cnt_b), int'(ov_b), int'(st_b));
   end

   initial forever begin
      @(negedge rst_n);
      q_a.delete();
      q_b.delete();
      rise_q.delete();
      for (int d = 0; d < 2; d++) begin
         hold_cnt[d] = 0;
         hold_ov[d]  = 0;
         hold_st[d]  = 0;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // A clean low-to-high run is counted DEBOUNCE+2 edges after it is first sampled.
   task automatic applyStimulus(input bit lvl, input int len);
      for (int i = 0; i < len; i++) begin
         @(negedge clk_in);
         tach_in = lvl;
         if (i == 0 && len >= D && lvl && !clean_lvl) rise_q.push_back(edge_no + 3 + D);
      end
      if (len >= D) clean_lvl = lvl;
   endtask

   task automatic squareWave(input int hi, input int lo, input int cycles);
      for (int i = 0; i < cycles; i += hi + lo) begin
         applyStimulus(1'b1, hi);
         applyStimulus(1'b0, lo);
      end
   endtask

   task automatic randomTach(input int cycles);
      int used;
      int a;
      int b;
      bit lvl;
      used = 0;
      lvl  = ~clean_lvl;
      while (used < cycles) begin
         a = int'($urandom_range(D, 7));
         applyStimulus(lvl, a);
         used += a;
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(~lvl, 1);
            b = int'($urandom_range(D, 6));
            applyStimulus(lvl, b);
            used += 1 + b;
         end
         lvl = ~lvl;
      end
   endtask

   task automatic randomEnable(input int cycles);
      int used;
      int n;
      used = 0;
      while (used < cycles) begin
         enable = 1'b1;
         n = int'($urandom_range(5, 70));
         waitCycles(n);
         used += n;
         enable = 1'b0;
         n = int'($urandom_range(1, 6));
         waitCycles(n);
         used += n;
      end
      enable = 1'b1;
   endtask

   task automatic waitGate(input int g);
      int guard;
      guard = 0;
      while (!(m_open[0] && (edge_no - m_start[0] == g)) && guard < 80) begin
         @(negedge clk_in);
         guard++;
      end
      checkOutput("gate position reached", (guard < 80) ? 1 : 0, 1);
   endtask

   initial begin : stimulus
      #1 rst_n = 1'b0;
      waitCycles(3);
      rst_n = 1'b1;

      waitCycles(50);
      checkDut("idle after reset A", 0, 0, 0, 0);
      checkDut("idle after reset B", 1, 0, 0, 0);

      squareWave(2, 2, 4 * int'($urandom_range(2, 4)));
      enable = 1'b1;
      squareWave(2, 2, 180);
      checkDut("period-4 A", 0, 5, 0, 0);
      checkDut("period-4 saturated B", 1, 15, 1, 0);

      squareWave(4, 4, 200);
      checkDut("period-8 B", 1, 10, 0, 0);

      squareWave(1, 5, 264);
      checkDut("glitch A", 0, 0, 0, 1);
      checkDut("glitch B", 1, 0, 0, 1);

      squareWave(2, 2, 60);
      checkDut("recovered A", 0, 5, 0, 0);
      fork
         squareWave(2, 2, 80);
         begin
            waitGate(10);
            enable = 1'b0;
            waitCycles(5);
            enable = 1'b1;
         end
      join

      fork
         randomTach(400);
         randomEnable(400);
      join
      applyStimulus(1'b0, 10);

      waitGate(7);
      #2 rst_n = 1'b0;
      #1;
      checkDut("mid-window reset A", 0, 0, 0, 0);
      checkDut("mid-window reset B", 1, 0, 0, 0);
      checkOutput("mid-window reset A count_valid", int'(valid_a), 0);
      checkOutput("mid-window reset B count_valid", int'(valid_b), 0);
      waitCycles(3);
      rst_n = 1'b1;
      squareWave(2, 2, 60);
      checkDut("after reset A", 0, 5, 0, 0);

      enable = 1'b0;
      waitCycles(5);
      checkOutput("A pending expectations", q_a.size(), 0);
      checkOutput("B pending expectations", q_b.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      bad++;
      $display("[TB] FAIL watchdog: got timeout at edge %0d, expected completion", edge_no);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
